spectro_serializer: RTL

SPECTRO_SERIALIZER -- requirements
Module: spectro_serializer

---
 rtl/spectro_serializer_pkg.sv | 24 ++
 rtl/piso_shift2.sv | 32 +++
 rtl/spectro_serializer.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/spectro_serializer_pkg.sv
// Shared types and default constants for the spectrogram frame serializer.
package spectro_serializer_pkg;

  localparam int TS_W_DEF   = 16;
  localparam int WORD_W_DEF = 8;
  localparam int N_BINS_DEF = 8;
  localparam int N_CH_DEF   = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TS   = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Frame length in bit-pair cycles: timestamp pairs plus all bin-word pairs.
  function automatic int frame_cycles(input int ts_w, input int word_w,
                                      input int n_bins, input int n_ch);
    return ts_w / 2 + (n_ch * n_bins * word_w) / 2;
  endfunction

  localparam int FRAME_CYCLES_DEF = frame_cycles(TS_W_DEF, WORD_W_DEF, N_BINS_DEF, N_CH_DEF);

endpackage

// File: rtl/piso_shift2.sv
// Parallel-load shifter emitting two bits per cycle, MSB first.
module piso_shift2
  import spectro_serializer_pkg::*;
#(
  parameter int W = TS_W_DEF
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic         shift_i,
  input  logic         clear_i,
  input  logic [W-1:0] data_i,
  output logic [1:0]   pair_o
);

  logic [W-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    if (clear_i)      sr_d = '0;
    else if (load_i)  sr_d = data_i;
    else if (shift_i) sr_d = {sr_q[W-3:0], 2'b00};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sr_q <= '0;
    else       sr_q <= sr_d;
  end

  assign pair_o = sr_q[W-1:W-2];

endmodule

// File: rtl/spectro_serializer.sv
// Streams a timestamp followed by every spectrogram bin word over a two-lane link.
//   state   | meaning
//   IDLE    | waiting for start; all outputs quiet
//   TS      | shifting out the captured timestamp
//   DATA    | shifting out bin words, ch0 bins then ch1 bins
//   DONE    | one-cycle done pulse, then back to IDLE
module spectro_serializer
  import spectro_serializer_pkg::*;
#(
  parameter int TS_W   = TS_W_DEF,
  parameter int WORD_W = WORD_W_DEF,
  parameter int N_BINS = N_BINS_DEF,
  parameter int N_CH   = N_CH_DEF
) (
  input  logic                              input_serial_readout_clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [TS_W-1:0]                   timestamp,
  output logic [$clog2(N_CH*N_BINS)-1:0]    mem_addr,
  output logic                              mem_ren,
  input  logic [WORD_W-1:0]                 mem_rdata,
  output logic [1:0]                        serial_out,
  output logic                              SL_time,
  output logic                              SL_ch,
  output logic                              sending_data,
  output logic                              done
);

  localparam int SR_W    = (TS_W > WORD_W) ? TS_W : WORD_W;
  localparam int CW      = $clog2(SR_W);
  localparam int N_WORDS = N_CH * N_BINS;
  localparam int AW      = $clog2(N_WORDS);

  localparam logic [CW-1:0] TS_LAST   = CW'(TS_W / 2 - 1);
  localparam logic [CW-1:0] WD_LAST   = CW'(WORD_W / 2 - 1);
  localparam logic [AW-1:0] WORD_LAST = AW'(N_WORDS - 1);
  localparam logic [AW:0]   N_WORDS_F = (AW+1)'(N_WORDS);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   word_q, word_d;
  logic [AW:0]     fetch_q, fetch_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            ren_q, ren_d;
  logic            sl_time_q, sl_time_d;
  logic            sl_ch_q, sl_ch_d;
  logic            send_q, send_d;
  logic            done_q, done_d;
  logic            sr_load, sr_shift, sr_clear;
  logic [SR_W-1:0] sr_data;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    word_d    = word_q;
    fetch_d   = fetch_q;
    addr_d    = addr_q;
    ren_d     = 1'b0;
    sl_time_d = 1'b0;
    sl_ch_d   = 1'b0;
    send_d    = 1'b0;
    done_d    = 1'b0;
    sr_load   = 1'b0;
    sr_shift  = 1'b0;
    sr_clear  = 1'b0;
    sr_data   = '0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_TS;
          cnt_d     = TS_LAST;
          word_d    = '0;
          fetch_d   = '0;
          sr_load   = 1'b1;
          sr_data   = SR_W'(timestamp) << (SR_W - TS_W);
          sl_time_d = 1'b1;
          send_d    = 1'b1;
        end
      end
      ST_TS: begin
        send_d = 1'b1;
        if (cnt_q == '0) begin
          state_d = ST_DATA;
          cnt_d   = WD_LAST;
          sr_load = 1'b1;
          sr_data = SR_W'(mem_rdata) << (SR_W - WORD_W);
        end else begin
          cnt_d     = cnt_q - CW'(1);
          sr_shift  = 1'b1;
          sl_time_d = 1'b1;
        end
      end
      ST_DATA: begin
        if (cnt_q == '0) begin
          if (word_q == WORD_LAST) begin
            state_d  = ST_DONE;
            sr_clear = 1'b1;
            done_d   = 1'b1;
          end else begin
            word_d  = word_q + AW'(1);
            cnt_d   = WD_LAST;
            sr_load = 1'b1;
            sr_data = SR_W'(mem_rdata) << (SR_W - WORD_W);
            send_d  = 1'b1;
            sl_ch_d = 1'((int'(word_d) / N_BINS) & 1);
          end
        end else begin
          cnt_d    = cnt_q - CW'(1);
          sr_shift = 1'b1;
          send_d   = 1'b1;
          sl_ch_d  = sl_ch_q;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Read strobe lands in the second-to-last pair of a field so the word arrives on the boundary.
    if ((state_d == ST_TS || state_d == ST_DATA) && cnt_d == CW'(1) && fetch_d < N_WORDS_F) begin
      ren_d   = 1'b1;
      addr_d  = fetch_d[AW-1:0];
      fetch_d = fetch_d + (AW+1)'(1);
    end
  end

  always_ff @(posedge input_serial_readout_clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      word_q    <= '0;
      fetch_q   <= '0;
      addr_q    <= '0;
      ren_q     <= 1'b0;
      sl_time_q <= 1'b0;
      sl_ch_q   <= 1'b0;
      send_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      word_q    <= word_d;
      fetch_q   <= fetch_d;
      addr_q    <= addr_d;
      ren_q     <= ren_d;
      sl_time_q <= sl_time_d;
      sl_ch_q   <= sl_ch_d;
      send_q    <= send_d;
      done_q    <= done_d;
    end
  end

  piso_shift2 #(.W(SR_W)) u_shift (
    .clk_i   (input_serial_readout_clk),
    .rst_i   (reset),
    .load_i  (sr_load),
    .shift_i (sr_shift),
    .clear_i (sr_clear),
    .data_i  (sr_data),
    .pair_o  (serial_out)
  );

  assign mem_addr     = addr_q;
  assign mem_ren      = ren_q;
  assign SL_time      = sl_time_q;
  assign SL_ch        = sl_ch_q;
  assign sending_data = send_q;
  assign done         = done_q;

endmodule
